// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with built-in decoder: single-cycle logic ops plus
// iterative MUL/DIVU/REMU (one bit per cycle), valid/ready on both sides.
module alu_mc #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   aluop,
  input  logic [3:0]   funct,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         illegal,
  output logic         busy,
  output logic [1:0]   o_dbg_state
);

  localparam int SHW = $clog2(n);
  localparam int CW  = $clog2(n) + 1;

  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_DIVU = 4'b1010;
  localparam logic [3:0] C_REMU = 4'b1011;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready.

  state_t         r_state, w_next;
  logic [3:0]     r_ctrl;
  logic [n-1:0]   r_a, r_q, r_acc, r_result;
  logic [CW-1:0]  r_cnt;
  logic           r_zero, r_illegal;

  logic [3:0]     w_ctrl;
  logic           w_multi;
  logic [n-1:0]   w_single;
  logic [SHW-1:0] w_sh;
  logic [n-1:0]   w_mul_acc;
  logic [n:0]     w_rem_sh;
  logic [n+1:0]   w_trial;
  logic           w_fits;
  logic [n-1:0]   w_rem_next;
  logic [n-1:0]   w_quo_next;

  always_comb begin
    w_ctrl = funct;
    case (aluop)
      2'b00:   w_ctrl = C_ADD;
      2'b01:   w_ctrl = C_SUB;
      2'b11:   w_ctrl = funct[3] ? C_ADD : funct;
      default: w_ctrl = funct;
    endcase
  end

  assign w_multi = (w_ctrl == C_MUL) || (w_ctrl == C_DIVU) || (w_ctrl == C_REMU);
  assign w_sh    = b[SHW-1:0];

  always_comb begin
    w_single = '0;
    case (w_ctrl)
      4'b0000: w_single = a & b;
      4'b0001: w_single = a | b;
      4'b0010: w_single = a + b;
      4'b0011: w_single = a ^ b;
      4'b0100: w_single = a << w_sh;
      4'b0101: w_single = a >> w_sh;
      4'b0110: w_single = a - b;
      4'b0111: w_single = n'($signed(a) < $signed(b));
      4'b1001: w_single = $unsigned($signed(a) >>> w_sh);
      default: w_single = '0;
    endcase
  end

  // MUL: r_a = shifted multiplicand, r_q = multiplier consumed LSB first.
  // DIV/REM: r_a = divisor, r_q = dividend shifting out / quotient shifting in, r_acc = remainder.
  assign w_mul_acc  = r_acc + (r_q[0] ? r_a : '0);
  assign w_rem_sh   = {r_acc, r_q[n-1]};
  assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_a};
  assign w_fits     = ~w_trial[n+1];
  assign w_rem_next = w_fits ? w_trial[n-1:0] : w_rem_sh[n-1:0];
  assign w_quo_next = {r_q[n-2:0], w_fits};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_multi ? S_CALC : S_DONE;
      S_CALC:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_ctrl <= w_ctrl;
          if (w_multi) begin
            r_a   <= (w_ctrl == C_MUL) ? a : b;
            r_q   <= (w_ctrl == C_MUL) ? b : a;
            r_acc <= '0;
            r_cnt <= CW'(n);
          end else begin
            r_result  <= w_single;
            r_zero    <= (w_single == '0);
            r_illegal <= (w_ctrl[3:2] == 2'b11);
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_ctrl == C_MUL) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_q   <= r_q >> 1;
          end else begin
            r_acc <= w_rem_next;
            r_q   <= w_quo_next;
          end
          if (r_cnt == CW'(1)) begin
            if (r_ctrl == C_MUL) begin
              r_result <= w_mul_acc;
              r_zero   <= (w_mul_acc == '0);
            end else if (r_ctrl == C_DIVU) begin
              r_result <= w_quo_next;
              r_zero   <= (w_quo_next == '0);
            end else begin
              r_result <= w_rem_next;
              r_zero   <= (w_rem_next == '0);
            end
            r_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_CALC);
  assign result      = r_result;
  assign zero        = r_zero;
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule
